// File: rtl/pipeline_pkg.sv
// Shared definitions for the instruction-fetch stage: fetch state codes,
// reset/NOP defaults, word size and a word-alignment helper.
package pipeline_pkg;

  // Fetch state encoding (2-bit)
  typedef logic [1:0] fetch_state_t;

  localparam logic [1:0] S_REQ   = 2'd0;  // request open, waiting for fresh data
  localparam logic [1:0] S_VALID = 2'd1;  // buffer holds the instruction for PCF
  localparam logic [1:0] S_DROP  = 2'd2;  // request open, response is stale

  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [31:0] WORD_BYTES    = 32'd4;

  // Force a byte address onto a word boundary for the memory port
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs a single-outstanding req/ack
// instruction-memory port, applies ID redirects, presents NOP bubbles while
// a fetch is pending and discards responses made stale by a redirect.
//
// Memory handshake: imem_req is held high from the cycle a request opens
// until (and including) the cycle imem_ack is seen; imem_addr is stable for
// the whole transaction. imem_ack is a one-cycle strobe with imem_rdata
// valid alongside it; an ack while imem_req is low is ignored. If imem_req
// stays high after an ack, a new transaction begins the next cycle
// (possibly to a new address).
module if_fetch_unit
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        PCSrcD,
  input  logic        JumpD,
  input  logic [31:0] PCBranchD,
  input  logic [31:0] PCJumpD,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PCF,
  output logic [31:0] PCPlus4F,
  output logic [31:0] InstrF,
  output logic        InstrValidF,
  output logic [1:0]  fetch_state
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  buffer;
  logic [31:0]  pend_pc;

  logic         redir;
  logic [31:0]  target;
  logic         ack;
  logic [31:0]  pc_seq;
  logic [31:0]  drop_pc;

  // Redirects from a stalled ID are not real yet; the branch wins over a jump
  assign redir   = (PCSrcD | JumpD) & ~StallD;
  assign target  = PCSrcD ? PCBranchD : PCJumpD;
  // Only an ack against an open request counts
  assign ack     = imem_ack & imem_req;
  assign pc_seq  = pc + WORD_BYTES;
  // A redirect in the same cycle as the stale ack is newer than the pending PC
  assign drop_pc = redir ? target : pend_pc;

  // Fetch FSM, PC register, next-PC selection and memory request registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_REQ;
      pc        <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= word_align(RESET_PC);
      buffer    <= NOP_INSTR;
      pend_pc   <= RESET_PC;
    end else begin
      case (state)
        S_REQ: begin
          if (!imem_req) begin
            // First cycle after reset: open the request at the current PC
            if (redir) pc <= target;
            imem_req  <= 1'b1;
            imem_addr <= word_align(redir ? target : pc);
          end else if (ack) begin
            if (redir) begin
              // Data is for a wrong-path PC; chain straight into the target
              pc        <= target;
              imem_addr <= word_align(target);
            end else begin
              buffer   <= imem_rdata;
              imem_req <= 1'b0;
              state    <= S_VALID;
            end
          end else if (redir) begin
            // Cannot move the address mid-transaction; remember where to go
            pend_pc <= target;
            state   <= S_DROP;
          end
        end
        S_VALID: begin
          if (redir) begin
            pc        <= target;
            imem_req  <= 1'b1;
            imem_addr <= word_align(target);
            state     <= S_REQ;
          end else if (!StallF) begin
            pc        <= pc_seq;
            imem_req  <= 1'b1;
            imem_addr <= word_align(pc_seq);
            state     <= S_REQ;
          end
        end
        S_DROP: begin
          if (ack) begin
            pc        <= drop_pc;
            imem_addr <= word_align(drop_pc);
            state     <= S_REQ;
          end else if (redir) begin
            pend_pc <= target;
          end
        end
        default: begin
          state    <= S_REQ;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

  // IF-side outputs: bubbles are NOPs, PC+4 wraps modulo 2^32
  always_comb begin
    PCF         = pc;
    PCPlus4F    = pc + WORD_BYTES;
    InstrValidF = (state == S_VALID);
    InstrF      = (state == S_VALID) ? buffer : NOP_INSTR;
    fetch_state = state;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch stage that produces the IF-side values (PCPlus4F, InstrF) consumed by the IF/ID pipeline register. It owns the PC register and drives a single-outstanding req/ack instruction-memory port. It applies branch and jump redirects from ID. It inserts NOP bubbles while a fetch is pending, and discards responses made stale by a redirect.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0000, instruction word presented while no valid fetch is available

Ports:
clk  input  1  system clock
rst_n  input  1  reset, synchronous, active-low
StallF  input  1  hazard unit: hold the fetched instruction and PC
StallD  input  1  hazard unit: ID is stalled; redirects are ignored while high
PCSrcD  input  1  taken branch resolved in ID
JumpD  input  1  jump in ID
PCBranchD  input  32  branch target
PCJumpD  input  32  jump target
imem_req  output  1  memory request, registered
imem_addr  output  32  request address, registered, word aligned
imem_ack  input  1  one-cycle response strobe; earliest arrival is the cycle after imem_req first goes high
imem_rdata  input  32  instruction word, valid with imem_ack
PCF  output  32  current fetch PC
PCPlus4F  output  32  PCF + 4, combinational, modulo 2^32
InstrF  output  32  fetched instruction, or NOP_INSTR when InstrValidF is low
InstrValidF  output  1  InstrF holds a real instruction for PCF

Behaviour:
- Redirect: redir = (PCSrcD | JumpD) & ~StallD.
  - Target is PCBranchD if PCSrcD is high, else PCJumpD. PCSrcD wins when both are high.
- States: S_REQ, S_VALID, S_DROP. The state register is a one-hot or 2-bit encoding.
- Reset (rst_n low at a clock edge): state <= S_REQ, PCF <= RESET_PC, imem_req <= 0, instruction buffer <= NOP_INSTR, pending PC <= RESET_PC.
  - After reset, outputs show InstrValidF=0, InstrF=NOP_INSTR, PCPlus4F=RESET_PC+4.
  - Reset during any state, including mid-request, wins over every other event. An ack arriving in the reset cycle is ignored.
- S_REQ:
  - imem_req=1, imem_addr=PCF. imem_req rises the first cycle after reset release.
  - On imem_ack & ~redir: buffer <= imem_rdata; go to S_VALID.
  - On imem_ack & redir: drop the data; PCF <= target; stay in S_REQ. imem_req stays high and imem_addr updates to the new PCF; back-to-back transactions are legal.
  - On redir & ~imem_ack: pending PC <= target; go to S_DROP. PCF and imem_addr must not change while the request is open.
- S_VALID:
  - imem_req=0, InstrValidF=1, InstrF=buffer.
  - On redir: PCF <= target; go to S_REQ. Redirect beats StallF.
  - Else if StallF: hold all state.
  - Else: PCF <= PCF+4; go to S_REQ.
- S_DROP:
  - imem_req=1 with the old imem_addr.
  - On imem_ack: discard the data; PCF <= pending PC; go to S_REQ.
  - A further redir while waiting overwrites the pending PC; the latest redirect wins.
  - If a redir and the ack occur in the same cycle, PCF <= the new target.
- Outputs outside S_VALID: InstrValidF=0, InstrF=NOP_INSTR. Bubbles flow into IF/ID as NOPs.
- StallF has no effect in S_REQ or S_DROP.
- PC arithmetic wraps: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- Throughput: one instruction per 2 cycles with a 1-cycle-latency memory. Throughput is lower with memory wait states.
- imem_ack received while imem_req is low is a protocol error. It is ignored and must not change state.

Decomposition:
- Shared package (pipeline_pkg): fetch state enum, NOP constant 32'h0, RESET_PC default, word-size constant 4.
- No sub-module is needed. The state register and next-PC mux live in one always block, plus a combinational output block.

Test Plan:
- Reset, then 1-cycle memory returning 32'h2008_0005 at address 0 -> imem_req high with addr 0; cycle 2 InstrValidF=1, InstrF=32'h2008_0005, PCPlus4F=4; then a request to addr 4.
- Memory with 3 wait states -> InstrF=NOP and InstrValidF=0 for 4 cycles, imem_addr stable, then valid for one cycle.
- S_VALID with StallF held 3 cycles -> PCF, InstrF and InstrValidF unchanged, imem_req=0; the fetch of PC+4 starts the cycle after StallF drops.
- PCSrcD=1, PCBranchD=32'h40 while a request to 32'h10 is outstanding -> S_DROP; the ack data is discarded; the next request has addr 32'h40.
- PCSrcD and JumpD both high, PCJumpD=32'h80, PCBranchD=32'h40 -> PCF=32'h40. The same redirect with StallD=1 -> ignored.
- PCF=32'hFFFF_FFFC, advance -> next imem_addr=0. rst_n low mid-request with an ack in the same cycle -> PCF=RESET_PC, InstrValidF=0.
